// File: rtl/psr_bank.sv
// CPSR plus five banked SPSRs with exception entry/return and error pulse.
// A single prioritised CPSR update per cycle; SPSR writes are side-band.
module psr_bank #(
  parameter logic [31:0] RESET_CPSR = 32'h0000_00D3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpsr_in,
  input  logic        cpsr_we,
  input  logic [3:0]  flags_in,
  input  logic        flag_we,
  input  logic [31:0] spsr_in,
  input  logic        spsr_we,
  input  logic        exc_entry,
  input  logic [4:0]  exc_mode,
  input  logic        exc_ret,
  output logic [31:0] cpsr_out,
  output logic [31:0] spsr_out,
  output logic        spsr_valid,
  output logic        psr_err
);

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  function automatic logic is_banked(input logic [4:0] m);
    return (m == MODE_FIQ) || (m == MODE_IRQ) || (m == MODE_SVC) ||
           (m == MODE_ABT) || (m == MODE_UND);
  endfunction

  function automatic logic is_legal(input logic [4:0] m);
    return is_banked(m) || (m == MODE_USR) || (m == MODE_SYS);
  endfunction

  function automatic logic [2:0] bank_idx(input logic [4:0] m);
    case (m)
      MODE_FIQ: return 3'd0;
      MODE_IRQ: return 3'd1;
      MODE_SVC: return 3'd2;
      MODE_ABT: return 3'd3;
      default:  return 3'd4;
    endcase
  endfunction

  logic [31:0]      cpsr_q, cpsr_nxt;
  logic [4:0][31:0] spsr_q, spsr_nxt;
  logic             err_nxt;
  logic [4:0]       cur_mode;
  logic             cur_banked;
  logic [31:0]      spsr_cur;

  assign cur_mode   = cpsr_q[4:0];
  assign cur_banked = is_banked(cur_mode);
  assign spsr_cur   = cur_banked ? spsr_q[bank_idx(cur_mode)] : 32'h0;

  always_comb begin
    cpsr_nxt = cpsr_q;
    spsr_nxt = spsr_q;
    err_nxt  = 1'b0;

    if (exc_entry) begin
      if (is_banked(exc_mode)) begin
        spsr_nxt[bank_idx(exc_mode)] = cpsr_q;
        cpsr_nxt[4:0] = exc_mode;
        cpsr_nxt[7]   = 1'b1;
        cpsr_nxt[6]   = cpsr_q[6] | (exc_mode == MODE_FIQ);
        cpsr_nxt[5]   = 1'b0;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (exc_ret) begin
      if (cur_banked) begin
        cpsr_nxt = spsr_cur;
        // A corrupt saved mode must never become the live mode.
        if (!is_legal(spsr_cur[4:0])) begin
          cpsr_nxt[4:0] = cur_mode;
          err_nxt       = 1'b1;
        end
      end else begin
        err_nxt = 1'b1;
      end
    end else if (cpsr_we) begin
      cpsr_nxt = cpsr_in;
      if (!is_legal(cpsr_in[4:0])) begin
        cpsr_nxt[4:0] = cur_mode;
        err_nxt       = 1'b1;
      end
    end else if (flag_we) begin
      cpsr_nxt[31:28] = flags_in;
    end

    // SPSR write targets the pre-update mode and yields to entry/return.
    if (spsr_we && !exc_entry && !exc_ret) begin
      if (cur_banked) spsr_nxt[bank_idx(cur_mode)] = spsr_in;
      else            err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpsr_q  <= RESET_CPSR;
      spsr_q  <= '0;
      psr_err <= 1'b0;
    end else begin
      cpsr_q  <= cpsr_nxt;
      spsr_q  <= spsr_nxt;
      psr_err <= err_nxt;
    end
  end

  assign cpsr_out   = cpsr_q;
  assign spsr_out   = spsr_cur;
  assign spsr_valid = cur_banked;

endmodule

// File: tb/tb_psr_bank.sv
// Directed bench for psr_bank: stimulus pushes expected state into a queue,
// a negedge monitor pops and compares against the DUT outputs.
module tb_psr_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpsr_in, spsr_in;
  logic        cpsr_we, flag_we, spsr_we, exc_entry, exc_ret;
  logic [3:0]  flags_in;
  logic [4:0]  exc_mode;
  logic [31:0] cpsr_out, spsr_out;
  logic        spsr_valid, psr_err;

  typedef struct {
    string       name;
    logic [31:0] cpsr;
    logic [31:0] spsr;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests  = 0;
  int   n_failed = 0;
  int   n_pushed = 0;

  always #5 clk = ~clk;

  psr_bank dut (
    .clk(clk), .reset(reset),
    .cpsr_in(cpsr_in), .cpsr_we(cpsr_we),
    .flags_in(flags_in), .flag_we(flag_we),
    .spsr_in(spsr_in), .spsr_we(spsr_we),
    .exc_entry(exc_entry), .exc_mode(exc_mode), .exc_ret(exc_ret),
    .cpsr_out(cpsr_out), .spsr_out(spsr_out),
    .spsr_valid(spsr_valid), .psr_err(psr_err)
  );

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (cpsr_out !== e.cpsr || spsr_out !== e.spsr ||
          spsr_valid !== e.valid || psr_err !== e.err) begin
        n_failed++;
        $display("FAIL %s: got cpsr=%h spsr=%h valid=%b err=%b, want cpsr=%h spsr=%h valid=%b err=%b",
                 e.name, cpsr_out, spsr_out, spsr_valid, psr_err,
                 e.cpsr, e.spsr, e.valid, e.err);
      end
    end
  end

  task automatic step(
    input string name,
    input logic rst, input logic cwe, input logic [31:0] cin,
    input logic fwe, input logic [3:0] fin,
    input logic swe, input logic [31:0] sin,
    input logic ee, input logic [4:0] em, input logic er,
    input logic [31:0] x_cpsr, input logic [31:0] x_spsr,
    input logic x_valid, input logic x_err);
    exp_t e;
    @(negedge clk);
    reset = rst; cpsr_we = cwe; cpsr_in = cin; flag_we = fwe; flags_in = fin;
    spsr_we = swe; spsr_in = sin; exc_entry = ee; exc_mode = em; exc_ret = er;
    @(posedge clk);
    #1;
    reset = 1'b0; cpsr_we = 1'b0; flag_we = 1'b0; spsr_we = 1'b0;
    exc_entry = 1'b0; exc_ret = 1'b0;
    e.name = name; e.cpsr = x_cpsr; e.spsr = x_spsr; e.valid = x_valid; e.err = x_err;
    sb.push_back(e);
    n_pushed++;
  endtask

  task automatic idle(input string name, input logic [31:0] x_cpsr,
                      input logic [31:0] x_spsr, input logic x_valid);
    step(name, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 0, x_cpsr, x_spsr, x_valid, 0);
  endtask

  initial begin
    reset = 1'b0; cpsr_we = 1'b0; cpsr_in = '0; flag_we = 1'b0; flags_in = '0;
    spsr_we = 1'b0; spsr_in = '0; exc_entry = 1'b0; exc_mode = '0; exc_ret = 1'b0;

    //   name            rst cwe cin           fwe fin  swe sin           ee em        er   cpsr          spsr          v  e
    step("reset",        1, 0, 32'h0,         0, 4'h0, 0, 32'h0,        0, 5'b00000, 0, 32'h0000_00D3, 32'h0,        1, 0);
    step("cpsr_we_usr",  0, 1, 32'h6000_0010, 0, 4'h0, 0, 32'h0,        0, 5'b00000, 0, 32'h6000_0010, 32'h0,        0, 0);
    step("flag_we",      0, 0, 32'h0,         1, 4'h2, 0, 32'h0,        0, 5'b00000, 0, 32'h2000_0010, 32'h0,        0, 0);
    step("entry_irq",    0, 0, 32'h0,         0, 4'h0, 0, 32'h0,        1, 5'b10010, 0, 32'h2000_0092, 32'h2000_0010, 1, 0);
    step("ret_irq",      0, 0, 32'h0,         0, 4'h0, 1, 32'hDEAD_BEEF, 0, 5'b00000, 1, 32'h2000_0010, 32'h0,        0, 0);
    step("cpsr_we_t",    0, 1, 32'h0000_0030, 0, 4'h0, 0, 32'h0,        0, 5'b00000, 0, 32'h0000_0030, 32'h0,        0, 0);
    step("entry_fiq",    0, 0, 32'h0,         0, 4'h0, 0, 32'h0,        1, 5'b10001, 0, 32'h0000_00D1, 32'h0000_0030, 1, 0);
    step("spsr_we_fiq",  0, 0, 32'h0,         0, 4'h0, 1, 32'h1234_5670, 0, 5'b00000, 0, 32'h0000_00D1, 32'h1234_5670, 1, 0);
    step("ret_fiq",      0, 0, 32'h0,         0, 4'h0, 0, 32'h0,        0, 5'b00000, 1, 32'h1234_5670, 32'h0,        0, 0);
    step("cwe_over_fwe", 0, 1, 32'hF000_001F, 1, 4'h0, 0, 32'h0,        0, 5'b00000, 0, 32'hF000_001F, 32'h0,        0, 0);
    step("entry_usr_err",0, 0, 32'h0,         0, 4'h0, 0, 32'h0,        1, 5'b10000, 0, 32'hF000_001F, 32'h0,        0, 1);
    idle("err_clears",   32'hF000_001F, 32'h0, 0);
    step("to_usr",       0, 1, 32'h0000_0010, 0, 4'h0, 0, 32'h0,        0, 5'b00000, 0, 32'h0000_0010, 32'h0,        0, 0);
    step("ret_usr_err",  0, 0, 32'h0,         0, 4'h0, 0, 32'h0,        0, 5'b00000, 1, 32'h0000_0010, 32'h0,        0, 1);
    step("spsr_usr_err", 0, 0, 32'h0,         0, 4'h0, 1, 32'hAAAA_5555, 0, 5'b00000, 0, 32'h0000_0010, 32'h0,        0, 1);
    step("bad_mode_cwe", 0, 1, 32'h8000_0000, 0, 4'h0, 0, 32'h0,        0, 5'b00000, 0, 32'h8000_0010, 32'h0,        0, 1);
    idle("err_clears2",  32'h8000_0010, 32'h0, 0);
    step("entry_illegal",0, 0, 32'h0,         0, 4'h0, 0, 32'h0,        1, 5'b10100, 0, 32'h8000_0010, 32'h0,        0, 1);
    step("entry_und_pri",0, 1, 32'h0000_001F, 0, 4'h0, 0, 32'h0,        1, 5'b11011, 0, 32'h8000_009B, 32'h8000_0010, 1, 0);
    step("spsr_und_flag",0, 0, 32'h0,         1, 4'hF, 1, 32'h4000_0015, 0, 5'b00000, 0, 32'hF000_009B, 32'h4000_0015, 1, 0);
    step("ret_bad_mode", 0, 0, 32'h0,         0, 4'h0, 0, 32'h0,        0, 5'b00000, 1, 32'h4000_001B, 32'h4000_0015, 1, 1);
    step("entry_svc",    0, 0, 32'h0,         0, 4'h0, 0, 32'h0,        1, 5'b10011, 0, 32'h4000_0093, 32'h4000_001B, 1, 0);
    step("reset_w_entry",1, 0, 32'h0,         0, 4'h0, 1, 32'h1111_1111, 1, 5'b10011, 0, 32'h0000_00D3, 32'h0,        1, 0);
    step("entry_abt",    0, 0, 32'h0,         0, 4'h0, 0, 32'h0,        1, 5'b10111, 0, 32'h0000_00D7, 32'h0000_00D3, 1, 0);
    step("ret_abt",      0, 0, 32'h0,         0, 4'h0, 0, 32'h0,        0, 5'b00000, 1, 32'h0000_00D3, 32'h0,        1, 0);
    step("to_usr2",      0, 1, 32'h0000_0010, 0, 4'h0, 0, 32'h0,        0, 5'b00000, 0, 32'h0000_0010, 32'h0,        0, 0);
    step("double_err",   0, 1, 32'h0000_0001, 0, 4'h0, 1, 32'h0,        0, 5'b00000, 0, 32'h0000_0010, 32'h0,        0, 1);
    idle("single_pulse", 32'h0000_0010, 32'h0, 0);

    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0 || n_tests != n_pushed + 1) begin
      n_failed++;
      $display("FAIL drain: %0d entries left, %0d checked, %0d pushed",
               sb.size(), n_tests - 1, n_pushed);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/psr_bank.md
PSR_BANK -- requirements
Module: psr_bank

Interface
REQ-001 Parameter RESET_CPSR, 32'h0000_00D3, CPSR value loaded on reset (SVC mode, I and F set, T clear).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpsr_in  input  32  full CPSR write value from the CPSR select mux output.
REQ-005 cpsr_we  input  1  write cpsr_in into CPSR this cycle.
REQ-006 flags_in  input  4  N,Z,C,V from ALU.
REQ-007 flag_we  input  1  write flags_in into CPSR[31:28] only.
REQ-008 spsr_in  input  32  write value for SPSR of current mode.
REQ-009 spsr_we  input  1  write spsr_in into SPSR bank of current mode.
REQ-010 exc_entry  input  1  exception entry request, one-cycle pulse.
REQ-011 exc_mode  input  5  target mode for exc_entry.
REQ-012 exc_ret  input  1  exception return: restore CPSR from SPSR of current mode.
REQ-013 cpsr_out  output  32  registered current CPSR.
REQ-014 spsr_out  output  32  SPSR of current mode; 0 in USR/SYS.
REQ-015 spsr_valid  output  1  1 when current mode owns an SPSR bank.
REQ-016 psr_err  output  1  registered one-cycle error pulse.

Function
REQ-017 Legal modes SHALL be USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111; all others illegal.
REQ-018 Block SHALL hold CPSR plus five 32-bit SPSR banks (FIQ, IRQ, SVC, ABT, UND); current mode = CPSR[4:0].
REQ-019 Per cycle exactly one CPSR update SHALL occur, priority: reset > exc_entry > exc_ret > cpsr_we > flag_we; lower-priority CPSR requests that cycle are dropped.
REQ-020 spsr_we SHALL be independent of CPSR priority, except exc_entry or exc_ret in same cycle override it (spsr_we dropped).
REQ-021 exc_entry with legal banked exc_mode: SPSR[exc_mode] <= CPSR; CPSR[4:0] <= exc_mode; CPSR[7] <= 1; CPSR[6] <= 1 only if exc_mode=FIQ, else unchanged; CPSR[5] <= 0; other bits unchanged; visible on cpsr_out next cycle.
REQ-022 exc_entry with exc_mode USR, SYS or illegal SHALL change no state and pulse psr_err.
REQ-023 exc_ret in banked mode: CPSR <= SPSR[current]; if restored mode field illegal, CPSR[4:0] SHALL be held and psr_err pulsed (other bits still restored).
REQ-024 exc_ret in USR/SYS SHALL change no state and pulse psr_err.
REQ-025 cpsr_we: CPSR <= cpsr_in; if cpsr_in[4:0] illegal, mode bits held, remaining bits written, psr_err pulsed.
REQ-026 flag_we: CPSR[31:28] <= flags_in; all other bits unchanged.
REQ-027 spsr_we in banked mode: SPSR[current] <= spsr_in (mode selected by CPSR before any same-cycle update); in USR/SYS ignored, psr_err pulsed.
REQ-028 spsr_out/spsr_valid SHALL be combinational from registered CPSR mode and banks; no bypass of same-cycle writes (one-cycle write-to-read latency).
REQ-029 psr_err SHALL be high for exactly the cycle after the offending request; multiple errors in one cycle yield one pulse.

Reset
REQ-030 On reset, CPSR <= RESET_CPSR, all five SPSR banks <= 0, psr_err <= 0; all same-cycle requests ignored.
REQ-031 After reset cpsr_out=32'h0000_00D3, spsr_out=0, spsr_valid=1 (SVC).
REQ-032 Reset asserted mid-sequence (e.g. concurrent exc_entry) SHALL leave no trace of the interrupted request.

Verification
REQ-033 Reset, then cpsr_we with cpsr_in=32'h6000_0010 -> cpsr_out=32'h6000_0010, spsr_valid=0, spsr_out=0.
REQ-034 From CPSR=32'h2000_0010, exc_entry exc_mode=10010 -> cpsr_out=32'h2000_0092, spsr_out=32'h2000_0010; then exc_ret -> cpsr_out=32'h2000_0010.
REQ-035 From USR, exc_entry exc_mode=10001 with CPSR=32'h0000_0030 -> cpsr_out=32'h0000_00D1, SPSR_FIQ=32'h0000_0030.
REQ-036 Same cycle cpsr_we (32'hF000_001F) and flag_we (4'h0) -> cpsr_out=32'hF000_001F; flags dropped.
REQ-037 In USR: exc_ret, then spsr_we, then cpsr_we with cpsr_in[4:0]=5'b00000 -> psr_err pulses each time, CPSR mode stays 10000.
REQ-038 exc_entry to SVC asserted together with reset -> cpsr_out=32'h0000_00D3, SPSR_SVC=0, psr_err=0.
